// File: rtl/als_sample_sequencer.sv
// Periodic ALS sample sequencer: requests SPI reads, averages 2**AVG_LOG2 words, hands the mean to the BCD converter.
// Optional peak-hold output is built when ALS_PEAK_HOLD_EN is defined.
module als_sample_sequencer #(
    parameter int DATA_W      = 8,
    parameter int PERIOD_CYC  = 100000,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_spi_start,
    input  logic [DATA_W-1:0] i_rx_byte,
    input  logic              i_rx_dv,
    output logic [DATA_W-1:0] o_bin,
    output logic              o_conv_start,
    input  logic              i_conv_dv,
    output logic              o_busy,
    output logic              o_timeout,
`ifdef ALS_PEAK_HOLD_EN
    input  logic              i_peak_clr,
    output logic [DATA_W-1:0] o_peak,
`endif
    output logic              o_overrun
);

    localparam int PCNT_W  = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;
    localparam int TCNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int ACC_W   = DATA_W + AVG_LOG2;
    localparam int SCNT_W  = AVG_LOG2 + 1;
    localparam int SAMPLES = 1 << AVG_LOG2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RX,
        CONV,
        WAIT_CONV
    } state_t;

    state_t              state;
    logic [PCNT_W-1:0]   period_cnt;
    logic [TCNT_W-1:0]   timeout_cnt;
    logic [ACC_W-1:0]    acc;
    logic [SCNT_W-1:0]   sample_cnt;

    logic                tick;
    logic [ACC_W-1:0]    acc_sum;
    logic                last_sample;
    logic                timeout_hit;

    assign tick        = (period_cnt == PCNT_W'(PERIOD_CYC - 1));
    assign acc_sum     = acc + ACC_W'(i_rx_byte);
    assign last_sample = (sample_cnt == SCNT_W'(SAMPLES - 1));
    // The count becomes TIMEOUT_CYC-1 on this edge, so the flag appears
    // TIMEOUT_CYC cycles after the request pulse (TIMEOUT_CYC >= 2).
    assign timeout_hit = (timeout_cnt == TCNT_W'(TIMEOUT_CYC - 2));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            timeout_cnt  <= '0;
            acc          <= '0;
            sample_cnt   <= '0;
            o_spi_start  <= 1'b0;
            o_bin        <= '0;
            o_conv_start <= 1'b0;
            o_busy       <= 1'b0;
            o_timeout    <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_spi_start  <= 1'b0;
            o_conv_start <= 1'b0;

            // A tick that finds the FSM busy is dropped, never queued.
            if (tick && state != IDLE) begin
                o_overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        state       <= REQ;
                        o_spi_start <= 1'b1;
                        o_busy      <= 1'b1;
                    end
                end
                REQ: begin
                    state       <= WAIT_RX;
                    timeout_cnt <= '0;
                end
                WAIT_RX: begin
                    if (i_rx_dv) begin
                        acc        <= acc_sum;
                        sample_cnt <= sample_cnt + SCNT_W'(1);
                        if (last_sample) begin
                            state        <= CONV;
                            o_bin        <= DATA_W'(acc_sum >> AVG_LOG2);
                            o_conv_start <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        // Partial accumulation survives a missed read.
                        o_timeout <= 1'b1;
                        state     <= IDLE;
                        o_busy    <= 1'b0;
                    end else begin
                        timeout_cnt <= timeout_cnt + TCNT_W'(1);
                    end
                end
                CONV: begin
                    acc        <= '0;
                    sample_cnt <= '0;
                    state      <= WAIT_CONV;
                end
                WAIT_CONV: begin
                    if (i_conv_dv) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALS_PEAK_HOLD_EN
    // o_bin is already stable while in CONV, so the peak follows one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_peak <= '0;
        end else if (state == CONV) begin
            if (i_peak_clr || (o_bin > o_peak)) begin
                o_peak <= o_bin;
            end
        end else if (i_peak_clr) begin
            o_peak <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_als_sample_sequencer.sv
// Randomized self-checking bench for als_sample_sequencer; expected averages come from a queue-based model.
module tb_als_sample_sequencer;

    localparam int PERIOD = 16;
    localparam int NAVG   = 4;
    localparam int TMO    = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_rx_byte = 8'd0;
    logic       i_rx_dv = 1'b0;
    logic       i_conv_dv = 1'b0;
    logic       o_spi_start;
    logic       o_conv_start;
    logic       o_busy;
    logic       o_timeout;
    logic       o_overrun;
    logic [7:0] o_bin;
`ifdef ALS_PEAK_HOLD_EN
    logic       i_peak_clr = 1'b0;
    logic [7:0] o_peak;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int edge_n    = 0;

    als_sample_sequencer #(
        .DATA_W(8),
        .PERIOD_CYC(PERIOD),
        .AVG_LOG2(2),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .o_spi_start(o_spi_start),
        .i_rx_byte(i_rx_byte),
        .i_rx_dv(i_rx_dv),
        .o_bin(o_bin),
        .o_conv_start(o_conv_start),
        .i_conv_dv(i_conv_dv),
        .o_busy(o_busy),
        .o_timeout(o_timeout),
`ifdef ALS_PEAK_HOLD_EN
        .i_peak_clr(i_peak_clr),
        .o_peak(o_peak),
`endif
        .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    // Clock edges since reset was released; requests are due on multiples of PERIOD.
    always @(posedge clk) edge_n <= rst_n ? edge_n + 1 : 0;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d passed=%0d", total_cnt, pass_cnt);
        $fatal(1, "watchdog");
    end

    function automatic int ref_avg(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s / NAVG;
    endfunction

    task automatic wait_spi(output bit ok, output int at_edge);
        ok = 1'b0;
        at_edge = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (o_spi_start === 1'b1) begin
                ok = 1'b1;
                at_edge = edge_n;
                break;
            end
        end
    endtask

    // Waits for a request, answers it d cycles later, returns what the converter side shows.
    task automatic send_sample(input int v, input int d, output bit ok, output int at_edge,
                               output logic cs, output logic [7:0] b);
        cs = 1'b0;
        b = 8'd0;
        wait_spi(ok, at_edge);
        if (!ok) return;
        repeat (d) @(negedge clk);
        i_rx_byte = v[7:0];
        i_rx_dv = 1'b1;
        @(negedge clk);
        i_rx_dv = 1'b0;
        i_rx_byte = 8'($urandom);
        cs = o_conv_start;
        b = o_bin;
    endtask

    task automatic finish_conv(input int delay);
        @(negedge clk);
        repeat (delay) @(negedge clk);
        i_conv_dv = 1'b1;
        @(negedge clk);
        i_conv_dv = 1'b0;
    endtask

    task automatic pulse_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        int e;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_rx_dv = (k % 2 == 0);
            i_conv_dv = (k % 2 == 1);
            i_rx_byte = 8'($urandom);
            @(negedge clk);
            total_cnt++;
            if ({o_spi_start, o_conv_start, o_busy, o_timeout, o_overrun, o_bin} !== 13'd0) begin
                $display("FAIL reset_outputs cycle %0d: got spi=%b conv=%b busy=%b to=%b ov=%b bin=%0d, expected all 0",
                         k, o_spi_start, o_conv_start, o_busy, o_timeout, o_overrun, o_bin);
            end else pass_cnt++;
        end
        i_rx_dv = 1'b0;
        i_conv_dv = 1'b0;
        rst_n = 1'b1;
        wait_spi(ok, e);
        total_cnt++;
        if (!ok || e !== PERIOD) begin
            $display("FAIL first_request: seen=%0b at edge %0d, expected edge %0d", ok, e, PERIOD);
        end else pass_cnt++;
        pulse_reset(2);
    endtask

    task automatic test_averaging();
        int   tbl[4][4] = '{'{10, 20, 30, 41}, '{255, 255, 255, 255}, '{0, 0, 0, 3}, '{1, 2, 3, 5}};
        bit   ok;
        int   e;
        logic cs;
        logic [7:0] b;
        for (int g = 0; g < 10; g++) begin
            int q[$];
            int expv;
            for (int s = 0; s < NAVG; s++) begin
                int v;
                v = (g < 4) ? tbl[g][s] : int'($urandom_range(0, 255));
                q.push_back(v);
                send_sample(v, int'($urandom_range(1, 6)), ok, e, cs, b);
                total_cnt++;
                if (!ok || (e % PERIOD) != 0) begin
                    $display("FAIL avg_g%0d_request%0d: seen=%0b at edge %0d, expected a multiple of %0d", g, s, ok, e, PERIOD);
                end else pass_cnt++;
                total_cnt++;
                if (cs !== (s == NAVG - 1)) begin
                    $display("FAIL avg_g%0d_conv_start%0d: got %b expected %b", g, s, cs, (s == NAVG - 1));
                end else pass_cnt++;
            end
            expv = ref_avg(q);
            total_cnt++;
            if (b !== expv[7:0]) begin
                $display("FAIL avg_g%0d_bin: got %0d expected %0d", g, b, expv);
            end else pass_cnt++;
            finish_conv(int'($urandom_range(0, 3)));
            total_cnt++;
            if (o_busy !== 1'b0 || o_bin !== expv[7:0]) begin
                $display("FAIL avg_g%0d_after_done: busy=%b bin=%0d, expected busy=0 bin=%0d", g, o_busy, o_bin, expv);
            end else pass_cnt++;
        end
    endtask

    task automatic test_ignored();
        bit   ok;
        int   e;
        int   d;
        int   q[$];
        int   expv;
        logic cs;
        logic [7:0] b;
        i_rx_byte = 8'd200;
        i_rx_dv = 1'b1;
        i_conv_dv = 1'b1;
        @(negedge clk);
        i_rx_dv = 1'b0;
        i_conv_dv = 1'b0;
        total_cnt++;
        if (o_busy !== 1'b0 || o_conv_start !== 1'b0) begin
            $display("FAIL ignored_idle: busy=%b conv=%b, expected 0 0", o_busy, o_conv_start);
        end else pass_cnt++;
        // Junk byte lands while the FSM is still in REQ and must be dropped.
        wait_spi(ok, e);
        i_rx_byte = 8'd250;
        i_rx_dv = 1'b1;
        @(negedge clk);
        d = int'($urandom_range(1, 6));
        q.push_back(int'($urandom_range(0, 255)));
        i_rx_byte = 8'(q[0]);
        repeat (d - 1) @(negedge clk);
        @(negedge clk);
        i_rx_dv = 1'b0;
        total_cnt++;
        if (o_busy !== 1'b0 || o_conv_start !== 1'b0) begin
            $display("FAIL ignored_first_sample: busy=%b conv=%b, expected 0 0", o_busy, o_conv_start);
        end else pass_cnt++;
        for (int s = 1; s < NAVG; s++) begin
            int v;
            v = int'($urandom_range(0, 255));
            q.push_back(v);
            send_sample(v, int'($urandom_range(1, 6)), ok, e, cs, b);
        end
        expv = ref_avg(q);
        total_cnt++;
        if (cs !== 1'b1 || b !== expv[7:0]) begin
            $display("FAIL ignored_avg: conv=%b bin=%0d, expected conv=1 bin=%0d", cs, b, expv);
        end else pass_cnt++;
        finish_conv(0);
    endtask

    task automatic test_timeout();
        bit   ok;
        int   e;
        logic cs;
        logic [7:0] b;
        // Answer on the very cycle the timeout would fire: data must win.
        send_sample(40, TMO - 1, ok, e, cs, b);
        total_cnt++;
        if (!ok || o_timeout !== 1'b0 || cs !== 1'b0) begin
            $display("FAIL timeout_coincide: seen=%0b timeout=%b conv=%b, expected 1 0 0", ok, o_timeout, cs);
        end else pass_cnt++;
        wait_spi(ok, e);
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            if (k == TMO - 1) begin
                total_cnt++;
                if (o_timeout !== 1'b0) begin
                    $display("FAIL timeout_early: got %b at cycle %0d, expected 0", o_timeout, k);
                end else pass_cnt++;
            end
        end
        total_cnt++;
        if (o_timeout !== 1'b1 || o_busy !== 1'b0) begin
            $display("FAIL timeout_flag: timeout=%b busy=%b, expected 1 0", o_timeout, o_busy);
        end else pass_cnt++;
        for (int s = 1; s < NAVG; s++) begin
            send_sample(40, int'($urandom_range(1, 6)), ok, e, cs, b);
            total_cnt++;
            if (cs !== (s == NAVG - 1)) begin
                $display("FAIL timeout_conv_start%0d: got %b expected %b", s, cs, (s == NAVG - 1));
            end else pass_cnt++;
        end
        total_cnt++;
        if (b !== 8'd40) begin
            $display("FAIL timeout_bin: got %0d expected 40", b);
        end else pass_cnt++;
        finish_conv(0);
    endtask

    task automatic test_overrun();
        bit   ok;
        int   e;
        int   y;
        int   expe;
        int   q[$];
        int   expv;
        logic cs;
        logic [7:0] b;
        logic spurious;
        total_cnt++;
        if (o_overrun !== 1'b0) begin
            $display("FAIL overrun_initial: got %b expected 0", o_overrun);
        end else pass_cnt++;
        for (int s = 0; s < NAVG; s++) begin
            int v;
            v = int'($urandom_range(0, 255));
            q.push_back(v);
            send_sample(v, int'($urandom_range(1, 6)), ok, e, cs, b);
        end
        expv = ref_avg(q);
        total_cnt++;
        if (cs !== 1'b1 || b !== expv[7:0]) begin
            $display("FAIL overrun_avg: conv=%b bin=%0d, expected conv=1 bin=%0d", cs, b, expv);
        end else pass_cnt++;
        spurious = 1'b0;
        repeat (20) begin
            @(negedge clk);
            spurious = spurious | o_spi_start;
        end
        total_cnt++;
        if (spurious !== 1'b0 || o_overrun !== 1'b1) begin
            $display("FAIL overrun_hold: spi_seen=%b overrun=%b, expected 0 1", spurious, o_overrun);
        end else pass_cnt++;
        i_conv_dv = 1'b1;
        @(negedge clk);
        i_conv_dv = 1'b0;
        y = edge_n;
        expe = ((y / PERIOD) + 1) * PERIOD;
        wait_spi(ok, e);
        total_cnt++;
        if (!ok || e !== expe || o_overrun !== 1'b1) begin
            $display("FAIL overrun_resume: seen=%0b edge=%0d overrun=%b, expected edge %0d overrun 1", ok, e, o_overrun, expe);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit   ok;
        int   e;
        int   expv;
        logic cs;
        logic [7:0] b;
        int   q[$];
        for (int s = 0; s < NAVG; s++) begin
            send_sample(int'($urandom_range(0, 255)), int'($urandom_range(1, 6)), ok, e, cs, b);
        end
        @(negedge clk);
        total_cnt++;
        if (o_busy !== 1'b1 || o_timeout !== 1'b1 || o_overrun !== 1'b1 || cs !== 1'b1) begin
            $display("FAIL rstmid_before: busy=%b timeout=%b overrun=%b conv=%b, expected 1 1 1 1", o_busy, o_timeout, o_overrun, cs);
        end else pass_cnt++;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({o_bin, o_busy, o_timeout, o_overrun, o_spi_start, o_conv_start} !== 13'd0) begin
            $display("FAIL rstmid_clear: bin=%0d busy=%b to=%b ov=%b spi=%b conv=%b, expected all 0",
                     o_bin, o_busy, o_timeout, o_overrun, o_spi_start, o_conv_start);
        end else pass_cnt++;
        rst_n = 1'b1;
        for (int round = 0; round < 2; round++) begin
            q.delete();
            for (int s = 0; s < NAVG; s++) begin
                int v;
                v = int'($urandom_range(0, 255));
                q.push_back(v);
                send_sample(v, int'($urandom_range(1, 6)), ok, e, cs, b);
                if (s == 0) begin
                    total_cnt++;
                    if (!ok || e !== PERIOD) begin
                        $display("FAIL rstmid_r%0d_first_request: seen=%0b edge=%0d expected %0d", round, ok, e, PERIOD);
                    end else pass_cnt++;
                end
            end
            expv = ref_avg(q);
            total_cnt++;
            if (cs !== 1'b1 || b !== expv[7:0]) begin
                $display("FAIL rstmid_r%0d_avg: conv=%b bin=%0d, expected conv=1 bin=%0d", round, cs, b, expv);
            end else pass_cnt++;
            finish_conv(0);
            if (round == 0) begin
                // Two samples accumulated, then reset: they must not leak into the next mean.
                for (int s = 0; s < 2; s++) begin
                    send_sample(255, int'($urandom_range(1, 6)), ok, e, cs, b);
                end
                pulse_reset(2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_averaging();
        test_ignored();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
